// File: rtl/divider_ctrl.sv
// divider_ctrl: IDLE/LOAD/RUN/DONE sequencer for a restoring divider, one quotient bit per RUN cycle.
// Define DIV_ZERO_CHECK_EN to enable the zero-divisor fast path and the div_by_zero flag.
module divider_ctrl #(
    parameter int nBit  = 16,
    parameter int CNT_W = 5
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    input  logic trial_neg,
    input  logic divisor_zero,
    output logic ld_op,
    output logic a_clr,
    output logic a_shl,
    output logic a_ld,
    output logic q_shl,
    output logic q_bit,
    output logic busy,
    output logic done,
    output logic div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(nBit - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             dbz_r;
    logic             dbz_hit_s;

`ifdef DIV_ZERO_CHECK_EN
    assign dbz_hit_s = (state_r == S_LOAD) && divisor_zero;
`else
    logic unused_divisor_zero_s;
    assign unused_divisor_zero_s = divisor_zero;
    assign dbz_hit_s = 1'b0;
`endif

    // Next-state selection; a zero divisor in LOAD bypasses the iterations
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_nxt_s = S_LOAD;
                else       state_nxt_s = S_IDLE;
            end
            S_LOAD: begin
                if (dbz_hit_s) state_nxt_s = S_DONE;
                else           state_nxt_s = S_RUN;
            end
            S_RUN: begin
                if (cnt_r == CNT_LAST) state_nxt_s = S_DONE;
                else                   state_nxt_s = S_RUN;
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State, iteration counter and the sticky zero-divisor flag
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= S_IDLE;
            cnt_r   <= CNT_ZERO;
            dbz_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == S_LOAD)     cnt_r <= CNT_ZERO;
            else if (state_r == S_RUN) cnt_r <= cnt_r + CNT_ONE;
            else                       cnt_r <= cnt_r;
            // flag survives DONE and IDLE; only an accepted start clears it
            if ((state_r == S_IDLE) && start) dbz_r <= 1'b0;
            else if (dbz_hit_s)               dbz_r <= 1'b1;
            else                              dbz_r <= dbz_r;
        end
    end

    // Strobe decode; the A-path choice and quotient bit follow trial_neg directly
    always_comb begin
        ld_op = 1'b0;
        a_clr = 1'b0;
        a_shl = 1'b0;
        a_ld  = 1'b0;
        q_shl = 1'b0;
        q_bit = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_r)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_LOAD: begin
                ld_op = 1'b1;
                a_clr = 1'b1;
                busy  = 1'b1;
            end
            S_RUN: begin
                busy  = 1'b1;
                q_shl = 1'b1;
                if (trial_neg) begin
                    a_shl = 1'b1;
                end else begin
                    a_ld  = 1'b1;
                    q_bit = 1'b1;
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_divider_ctrl.sv
// Bench for divider_ctrl: behavioural A/Q/M datapath on the falling edge, arithmetic reference model,
// per-cycle strobe comparison plus directed literal checks.
module tb_divider_ctrl;
    localparam int NB = 16;
`ifdef DIV_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          start = 1'b0;
    logic [NB-1:0] dividend = 16'd0;
    logic [NB-1:0] divisor = 16'd1;
    logic [NB-1:0] a_reg = 16'd0, q_reg = 16'd0, m_reg = 16'd0;
    logic          trial_neg, divisor_zero;
    logic          ld_op, a_clr, a_shl, a_ld, q_shl, q_bit, busy, done, div_by_zero;
    logic [8:0]    outvec;
    int            checks = 0;
    int            errors = 0;

    divider_ctrl #(.nBit(NB), .CNT_W(5)) dut (
        .clk(clk), .clr(clr), .start(start), .trial_neg(trial_neg), .divisor_zero(divisor_zero),
        .ld_op(ld_op), .a_clr(a_clr), .a_shl(a_shl), .a_ld(a_ld), .q_shl(q_shl), .q_bit(q_bit),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    assign outvec = {ld_op, a_clr, a_shl, a_ld, q_shl, q_bit, busy, done, div_by_zero};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Datapath: shift registers sample the strobes on the falling edge
    logic [NB-1:0] shifted;
    logic [NB:0]   trial;
    assign shifted      = {a_reg[NB-2:0], q_reg[NB-1]};
    assign trial        = {1'b0, shifted} - {1'b0, m_reg};
    assign trial_neg    = trial[NB];
    assign divisor_zero = (divisor == 16'd0);

    always @(negedge clk) begin
        if (ld_op) begin q_reg <= dividend; m_reg <= divisor; end
        if (a_clr) a_reg <= 16'd0;
        if (a_shl) a_reg <= shifted;
        if (a_ld)  a_reg <= trial[NB-1:0];
        if (q_shl) q_reg <= {q_reg[NB-2:0], q_bit};
    end

    // Reference model: m_md is the cycle index after the accepting edge (1 = load, last = done)
    logic          m_op = 1'b0, m_fast = 1'b0, m_dbz = 1'b0;
    int            m_md = 0;
    logic [NB-1:0] m_q = 16'd0, m_r = 16'd0;

    function automatic int op_len(input logic fast);
        return fast ? 2 : NB + 2;
    endfunction

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_op <= 1'b0; m_md <= 0; m_dbz <= 1'b0; m_fast <= 1'b0;
        end else if (!m_op) begin
            if (start) begin
                m_op   <= 1'b1;
                m_md   <= 1;
                m_dbz  <= 1'b0;
                m_fast <= ZC && (divisor == 16'd0);
                if (divisor == 16'd0) begin
                    m_q <= ZC ? dividend : 16'hFFFF;
                    m_r <= ZC ? 16'd0 : dividend;
                end else begin
                    m_q <= dividend / divisor;
                    m_r <= dividend % divisor;
                end
            end
        end else begin
            if (m_md == op_len(m_fast)) m_op <= 1'b0;
            else                        m_md <= m_md + 1;
            if (m_fast && m_md == 1)    m_dbz <= 1'b1;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic [8:0] exp_v;
        logic       b;
        exp_v    = 9'd0;
        exp_v[0] = m_dbz;
        if (m_op) begin
            if (m_md == 1) begin
                exp_v[8] = 1'b1; exp_v[7] = 1'b1; exp_v[2] = 1'b1;
            end else if (m_md == op_len(m_fast)) begin
                exp_v[1] = 1'b1;
            end else begin
                b = m_q[NB - 1 - (m_md - 2)];
                exp_v[6] = ~b; exp_v[5] = b; exp_v[4] = 1'b1; exp_v[3] = b; exp_v[2] = 1'b1;
            end
        end
        chk("strobes", {23'd0, outvec}, {23'd0, exp_v});
        if (m_op && m_md == op_len(m_fast)) begin
            chk("model_quotient", {16'd0, q_reg}, {16'd0, m_q});
            chk("model_remainder", {16'd0, a_reg}, {16'd0, m_r});
        end
    end

    int            lat, busy_n, ald_n, ashl_n, done_n;
    logic          dbz_at_done;
    logic [NB-1:0] res_q, res_r;

    // mode 0: plain; mode 1: re-pulse start in RUN and in DONE, then watch for extra done
    task automatic do_div(input logic [NB-1:0] dd, input logic [NB-1:0] dv, input int mode);
        logic got;
        @(posedge clk); #1;
        dividend = dd; divisor = dv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busy_n = 0; ald_n = 0; ashl_n = 0; done_n = 0; got = 1'b0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            busy_n += int'(busy); ald_n += int'(a_ld); ashl_n += int'(a_shl);
            if (done) begin
                got = 1'b1; res_q = q_reg; res_r = a_reg; dbz_at_done = div_by_zero;
            end
            if (mode == 1 && (lat == 5 || got)) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        if (!got) chk("done_timeout", {31'd0, got}, 32'd1);
        if (mode == 1) begin
            repeat (4) begin @(negedge clk); done_n += int'(done); end
        end
    endtask

    initial begin
        #12;
        chk("reset_outputs", {23'd0, outvec}, 32'd0);
        @(posedge clk); #1 clr = 1'b1;

        do_div(16'd100, 16'd7, 0);
        chk("t1_latency", lat, 32'd18);
        chk("t1_busy_cycles", busy_n, 32'd17);
        chk("t1_q", {16'd0, res_q}, 32'd14);
        chk("t1_r", {16'd0, res_r}, 32'd2);

        do_div(16'hFFFF, 16'd1, 0);
        chk("t2_q", {16'd0, res_q}, 32'hFFFF);
        chk("t2_r", {16'd0, res_r}, 32'd0);
        chk("t2_a_ld_cycles", ald_n, 32'd16);
        chk("t2_a_shl_cycles", ashl_n, 32'd0);

        do_div(16'd5, 16'd0, 0);
        chk("t3_latency", lat, ZC ? 32'd2 : 32'd18);
        chk("t3_q", {16'd0, res_q}, ZC ? 32'd5 : 32'hFFFF);
        chk("t3_r", {16'd0, res_r}, ZC ? 32'd0 : 32'd5);
        chk("t3_div_by_zero", {31'd0, dbz_at_done}, {31'd0, ZC});

        do_div(16'd100, 16'd7, 1);
        chk("t4_latency", lat, 32'd18);
        chk("t4_q", {16'd0, res_q}, 32'd14);
        chk("t4_r", {16'd0, res_r}, 32'd2);
        chk("t4_extra_done", done_n, 32'd0);

        // abort in the fifth RUN cycle
        @(posedge clk); #1;
        dividend = 16'd100; divisor = 16'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5_busy_before_abort", {31'd0, busy}, 32'd1);
        #1 clr = 1'b0;
        #1 chk("t5_abort_outputs", {23'd0, outvec}, 32'd0);
        done_n = 0;
        repeat (3) begin @(negedge clk); done_n += int'(done); end
        @(posedge clk); #1 clr = 1'b1;
        repeat (20) begin @(negedge clk); done_n += int'(done); end
        chk("t5_no_done", done_n, 32'd0);
        do_div(16'd9, 16'd3, 0);
        chk("t5_q", {16'd0, res_q}, 32'd3);
        chk("t5_r", {16'd0, res_r}, 32'd0);

        do_div(16'd200, 16'd9, 0);
        chk("t6a_q", {16'd0, res_q}, 32'd22);
        chk("t6a_r", {16'd0, res_r}, 32'd2);
        do_div(16'd17, 16'd17, 0);
        chk("t6b_q", {16'd0, res_q}, 32'd1);
        chk("t6b_r", {16'd0, res_r}, 32'd0);
        chk("t6b_latency", lat, 32'd18);

        repeat (25) begin
            logic [NB-1:0] rd, rv;
            rd = NB'($urandom);
            rv = ($urandom_range(0, 7) == 0) ? 16'd0 : NB'($urandom_range(1, 32'h7FFF));
            do_div(rd, rv, 0);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/divider_ctrl.md
# divider_ctrl

Sequencing controller for the restoring-division datapath. It drives the load/shift/clear controls of the remainder (A), quotient (Q) and divisor (M) shift registers one quotient bit per cycle, using the trial-subtraction sign fed back from the datapath. It presents a start/busy/done handshake to the enclosing system.

## Interface
- nBit, 16: operand width; sets the iteration count
- CNT_W, 5: iteration counter width; must satisfy 2^CNT_W > nBit
- clk  in  1  system clock; all state updates on the rising edge
- clr  in  1  reset, asynchronous, active-low
- start  in  1  request a division; sampled only in IDLE
- trial_neg  in  1  sign of datapath trial result ({A[nBit-2:0],Q[nBit-1]} − M); 1 = negative
- divisor_zero  in  1  datapath flag, M input bus == 0
- ld_op  out  1  load Q ← dividend and M ← divisor
- a_clr  out  1  clear A
- a_shl  out  1  shift A left; datapath wires Shift_In = Q[nBit-1]
- a_ld  out  1  load A ← trial difference
- q_shl  out  1  shift Q left
- q_bit  out  1  Shift_In value for Q (new quotient bit)
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse; results valid in A (remainder) and Q (quotient)
- div_by_zero  out  1  error flag; held from done until the next accepted start or reset

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: all strobes 0. start=1 → LOAD.
- LOAD (1 cycle): ld_op=1, a_clr=1, busy=1, cnt ← 0, div_by_zero ← 0. Next state is RUN; with DIV_ZERO_CHECK_EN and divisor_zero=1, next state is DONE instead.
- RUN (nBit cycles): busy=1, q_shl=1 every cycle.
  - trial_neg=1: a_shl=1, q_bit=0.
  - trial_neg=0: a_ld=1, q_bit=1.
  - a_shl and a_ld are never both 1.
  - cnt increments each cycle; when cnt == nBit−1 → DONE.
- DONE (1 cycle): done=1, busy=0, all datapath strobes 0 → IDLE.
- start is ignored outside IDLE, including when asserted during DONE.
- Strobes are Moore outputs except a_shl, a_ld and q_bit, which are combinational from state and trial_neg.
- Strobes change after the rising edge and are stable at the following falling edge, where the shift registers sample.

## Timing
- Reset (clr=0), at any time: state=IDLE, cnt=0, every output 0. Datapath register contents are undefined afterwards.
- Reset mid-operation aborts with no done pulse.
- Normal latency: start sampled at edge k; LOAD during cycle k+1; RUN during cycles k+2 … k+nBit+1; done=1 during cycle k+nBit+2.
- Back-to-back operation: next start is accepted at the earliest in IDLE, 1 cycle after done. Minimum period is nBit+3 cycles.
- Zero-divisor fast path (macro on): done occurs 2 cycles after start is sampled.

## Configuration
- DIV_ZERO_CHECK_EN defined:
  - divisor_zero is sampled in LOAD.
  - If it is 1: RUN is skipped, DONE asserts done together with div_by_zero=1, and Q/A keep their loaded values (Q = dividend, A = 0).
- DIV_ZERO_CHECK_EN undefined:
  - divisor_zero is ignored and div_by_zero is tied to 0.
  - A zero divisor runs the full nBit iterations and produces Q = all ones, A = dividend.

## Test plan
Bench pairs the controller with a behavioural A/Q/M datapath clocked on the falling edge.
- 100 ÷ 7, nBit=16 → done 18 cycles after start; Q=14, R=2; busy high for exactly 17 cycles.
- 0xFFFF ÷ 1 → Q=0xFFFF, R=0; a_ld asserted on all 16 RUN cycles; a_shl never asserted.
- 5 ÷ 0:
  - macro on → done 2 cycles after start, div_by_zero=1, Q=5.
  - macro off → done at 18 cycles, Q=0xFFFF, R=5, div_by_zero=0.
- start re-pulsed during RUN and during DONE → ignored; exactly one done pulse; result unchanged (100 ÷ 7 → 14 r 2).
- clr low at RUN cycle 5 → all outputs 0 immediately (asynchronous), no done pulse; a fresh 9 ÷ 3 afterwards → Q=3, R=0.
- Back-to-back 200 ÷ 9 then 17 ÷ 17, second start issued in the IDLE cycle after done → results 22 r 2 then 1 r 0.
